pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central hazard and sequencing controller for the five-stage pipelined RV32 core. It drives the write-enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable. It resolves load-use stalls, EX-stage redirects, data-memory wait states with timeout, and an externally requested halt with pipeline drain. The controller sits beside the datapath and is the only source of those control lines.

## Interface
- `DRAIN_CYCLES`, 3: negedges of drain before `halted` asserts.
- `MEM_TIMEOUT`, 255: maximum consecutive memory-wait cycles before timeout; valid range 1..65535.
- `CNT_W`, 32: width of the performance counters.
- `clk`  in  1  core clock; all state updates on the negedge, same edge as the pipeline registers.
- `rst`  in  1  asynchronous, active-low reset.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  the ID instruction actually reads rs1 / rs2.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_mem_read`  in  1  the EX instruction is a load.
- `ex_redirect`  in  1  taken branch or jump resolved in EX.
- `mem_req`  in  1  MEM stage is accessing data memory.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `halt_req`  in  1  level request to halt the core.
- `pc_we`  out  1  PC write enable.
- `ifid_we`, `ifid_flush`  out  1 each  IF/ID register control.
- `idex_we`, `idex_flush`  out  1 each  ID/EX register control.
- `exmem_we`, `exmem_flush`  out  1 each  EX/MEM register control.
- `memwb_we`, `memwb_flush`  out  1 each  MEM/WB register control.
- `halted`  out  1  pipeline is drained and frozen.
- `mem_timeout`  out  1  sticky memory timeout flag.
- `stall_cycles`, `flush_events`  out  CNT_W each  performance counters.

## Operation
- **FSM states.** The FSM has four states: RUN, HALT_DRAIN, HALTED and FAULT. `wait_cnt` is a 16-bit counter; `drain_cnt` is sized for `DRAIN_CYCLES`.
- **Output decoding.** Outputs are combinational from the current state and inputs. Default: every `*_we` = 1 and every `*_flush` = 0.
- **Decision priority within RUN and HALT_DRAIN** (highest first):
  1. **Memory stall** (`mem_req & ~mem_ready`):
     - `pc_we`, `ifid_we`, `idex_we` and `exmem_we` = 0.
     - `memwb_we` = 1 and `memwb_flush` = 1, so a bubble enters WB.
     - `wait_cnt` increments.
  2. **Redirect** (`ex_redirect`):
     - `pc_we` = 1.
     - `ifid_flush` = 1 and `idex_flush` = 1.
     - A simultaneous load-use condition is ignored, because that instruction is wrong-path.
  3. **Load-use** (`ex_mem_read & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))`):
     - `pc_we` = 0 and `ifid_we` = 0.
     - `idex_flush` = 1, so a bubble enters EX.
- **Memory-wait counter.**
  - `wait_cnt` clears on any cycle without a memory stall.
  - When `wait_cnt` reaches `MEM_TIMEOUT` with the stall still present, the FSM moves to FAULT and `mem_timeout` sets.
- **RUN → HALT_DRAIN.**
  - Taken when `halt_req`=1 and no memory stall is active.
  - `drain_cnt` loads `DRAIN_CYCLES`.
- **HALT_DRAIN.**
  - When neither a redirect nor a load-use is active: `pc_we` = 0 and `ifid_flush` = 1. The PC holds the unissued fetch address.
  - Redirect and load-use behave as in RUN and reload `drain_cnt`.
  - A memory stall freezes `drain_cnt`.
  - Otherwise `drain_cnt` decrements; at 0 the FSM moves to HALTED.
  - If `halt_req` drops during drain, the FSM returns to RUN.
- **HALTED.**
  - All `*_we` = 0 and `halted` = 1.
  - The FSM returns to RUN on the first negedge with `halt_req`=0.
- **FAULT.**
  - All `*_we` = 0; `halted` = 1 and `mem_timeout` = 1.
  - The FSM leaves FAULT only via reset.
- **Reset values.** On `rst` low:
  - State = RUN; `wait_cnt`, `drain_cnt` and the counters are 0; `mem_timeout` = 0.
  - All `*_we` and `*_flush` outputs are forced to 0 and `halted` = 0 while `rst` is low.

## Timing
- The controller has zero latency: outputs respond combinationally within the same cycle and are sampled by the pipeline registers at the next negedge.
- State, counters and `mem_timeout` update at that same negedge.
- Load-use costs exactly one bubble: on the following cycle the load is in MEM and the condition is false.
- A redirect costs two squashed slots (IF/ID and ID/EX), both at a single edge.
- Halt, with no hazards during the drain: `halted` rises after exactly `DRAIN_CYCLES`+1 negedges from the first negedge sampling `halt_req`=1.
- An asynchronous `rst` assertion mid-stall or mid-drain returns to RUN immediately. Pipeline register contents are not this block's concern.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cycles` increments on every cycle with a memory stall or load-use stall.
  - `flush_events` increments on every redirect.
  - Both counters saturate at all-ones and clear on reset.
- `PIPE_CTRL_PERF_EN` undefined: both ports are constant 0 and no counter flops are synthesized.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_use_rs1`=1 → for one cycle `pc_we`=0, `ifid_we`=0, `idex_flush`=1; with `ex_rd`=0 → no stall.
- Redirect plus load-use in the same cycle → `pc_we`=1, `ifid_flush`=1, `idex_flush`=1, `ifid_we`=1.
- `mem_req`=1 with `mem_ready` low for 4 cycles → `exmem_we`=0 and `memwb_flush`=1 for 4 cycles; `mem_ready`=1 → defaults restored at the same edge.
- `MEM_TIMEOUT`=8, `mem_ready` held low → after 8 wait cycles `mem_timeout`=1 and `halted`=1; both persist after `mem_ready` rises and clear only on `rst`=0.
- `halt_req` pulse held, `DRAIN_CYCLES`=3, no hazards → `halted`=1 on the 4th negedge. A redirect injected mid-drain reloads the count to 3. Dropping `halt_req` → RUN, with `pc_we`=1 next cycle.
- With `PIPE_CTRL_PERF_EN`: 2 load-use stalls + 3 wait cycles + 1 redirect → `stall_cycles`=5, `flush_events`=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage RV32 pipeline; all state moves on the negedge.
// Define PIPE_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned MEM_TIMEOUT  = 255,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_use_rs1_i,
   input  logic             id_use_rs2_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_mem_read_i,
   input  logic             ex_redirect_i,
   input  logic             mem_req_i,
   input  logic             mem_ready_i,
   input  logic             halt_req_i,
   output logic             pc_we_o,
   output logic             ifid_we_o,
   output logic             ifid_flush_o,
   output logic             idex_we_o,
   output logic             idex_flush_o,
   output logic             exmem_we_o,
   output logic             exmem_flush_o,
   output logic             memwb_we_o,
   output logic             memwb_flush_o,
   output logic             halted_o,
   output logic             mem_timeout_o,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [CNT_W-1:0] flush_events_o
);

   localparam int unsigned DrainW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
   localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES);
   // Stall cycle on which the incremented wait count reaches MEM_TIMEOUT.
   localparam logic [15:0] TimeoutLast = 16'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {StRun, StHaltDrain, StHalted, StFault} state_e;

   state_e             state_q, state_d;
   logic [15:0]        wait_cnt_q, wait_cnt_d;
   logic [DrainW-1:0]  drain_cnt_q, drain_cnt_d;
   logic               mem_timeout_q, mem_timeout_d;

   logic mem_stall;
   logic load_use;

   assign mem_stall = mem_req_i & ~mem_ready_i;
   assign load_use  = ex_mem_read_i & (ex_rd_i != 5'd0) &
                      ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                       (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

   // Pipeline register and PC controls.
   always_comb begin
      pc_we_o       = 1'b1;
      ifid_we_o     = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_we_o     = 1'b1;
      idex_flush_o  = 1'b0;
      exmem_we_o    = 1'b1;
      exmem_flush_o = 1'b0;
      memwb_we_o    = 1'b1;
      memwb_flush_o = 1'b0;
      halted_o      = 1'b0;
      case (state_q)
         StRun, StHaltDrain: begin
            if (mem_stall) begin
               pc_we_o       = 1'b0;
               ifid_we_o     = 1'b0;
               idex_we_o     = 1'b0;
               exmem_we_o    = 1'b0;
               memwb_flush_o = 1'b1;
            end else if (ex_redirect_i) begin
               // A coincident load-use belongs to the wrong path and is dropped.
               ifid_flush_o = 1'b1;
               idex_flush_o = 1'b1;
            end else if (load_use) begin
               pc_we_o      = 1'b0;
               ifid_we_o    = 1'b0;
               idex_flush_o = 1'b1;
            end else if (state_q == StHaltDrain) begin
               // Stop fetching; the PC keeps the first unissued address.
               pc_we_o      = 1'b0;
               ifid_flush_o = 1'b1;
            end
         end
         StHalted, StFault: begin
            pc_we_o    = 1'b0;
            ifid_we_o  = 1'b0;
            idex_we_o  = 1'b0;
            exmem_we_o = 1'b0;
            memwb_we_o = 1'b0;
            halted_o   = 1'b1;
         end
         default: ;
      endcase
      if (!rst_ni) begin
         pc_we_o       = 1'b0;
         ifid_we_o     = 1'b0;
         ifid_flush_o  = 1'b0;
         idex_we_o     = 1'b0;
         idex_flush_o  = 1'b0;
         exmem_we_o    = 1'b0;
         exmem_flush_o = 1'b0;
         memwb_we_o    = 1'b0;
         memwb_flush_o = 1'b0;
         halted_o      = 1'b0;
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = '0;
      drain_cnt_d   = drain_cnt_q;
      mem_timeout_d = mem_timeout_q;
      case (state_q)
         StRun, StHaltDrain: begin
            if (mem_stall) begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
            if (mem_stall && (wait_cnt_q >= TimeoutLast)) begin
               state_d       = StFault;
               mem_timeout_d = 1'b1;
            end else if (state_q == StRun) begin
               if (halt_req_i && !mem_stall) begin
                  state_d     = (DRAIN_CYCLES == 0) ? StHalted : StHaltDrain;
                  drain_cnt_d = DrainLoad;
               end
            end else if (!halt_req_i) begin
               state_d = StRun;
            end else if (mem_stall) begin
               drain_cnt_d = drain_cnt_q;
            end else if (ex_redirect_i || load_use) begin
               // New instructions still have to retire: restart the drain window.
               drain_cnt_d = DrainLoad;
            end else if (drain_cnt_q <= DrainW'(1)) begin
               state_d     = StHalted;
               drain_cnt_d = '0;
            end else begin
               drain_cnt_d = drain_cnt_q - DrainW'(1);
            end
         end
         StHalted: begin
            if (!halt_req_i) begin
               state_d = StRun;
            end
         end
         default: ;
      endcase
   end

   always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StRun;
         wait_cnt_q    <= '0;
         drain_cnt_q   <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         drain_cnt_q   <= drain_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign mem_timeout_o = mem_timeout_q;

`ifdef PIPE_CTRL_PERF_EN
   logic             active;
   logic             stall_evt;
   logic             flush_evt;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   assign active    = (state_q == StRun) || (state_q == StHaltDrain);
   assign stall_evt = active & (mem_stall | (~ex_redirect_i & load_use));
   assign flush_evt = active & ~mem_stall & ex_redirect_i;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_evt && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_evt && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cycles_o = stall_cnt_q;
   assign flush_events_o = flush_cnt_q;
`else
   assign stall_cycles_o = '0;
   assign flush_events_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a table-driven reference model.
// Inputs change just after each negedge; outputs are sampled just after the posedge.
module tb_pipe_hazard_ctrl;

   localparam int unsigned Drain   = 3;
   localparam int unsigned Timeout = 8;
   localparam int unsigned CntW    = 8;
   localparam int          CntMax  = (1 << CntW) - 1;

   localparam int ModeRun    = 0;
   localparam int ModeDrain  = 1;
   localparam int ModeHalted = 2;
   localparam int ModeFault  = 3;

   logic clk = 1'b1;
   always #5 clk = ~clk;

   logic            rst_n = 1'b0;
   logic [4:0]      id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic            id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
   logic            ex_mem_read = 1'b0, ex_redirect = 1'b0;
   logic            mem_req = 1'b0, mem_ready = 1'b1, halt_req = 1'b0;
   logic            pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
   logic            exmem_we, exmem_flush, memwb_we, memwb_flush, halted, mem_timeout;
   logic [CntW-1:0] stall_cycles, flush_events;

   pipe_hazard_ctrl #(
      .DRAIN_CYCLES (Drain),
      .MEM_TIMEOUT  (Timeout),
      .CNT_W        (CntW)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .id_rs1_i       (id_rs1),
      .id_rs2_i       (id_rs2),
      .id_use_rs1_i   (id_use_rs1),
      .id_use_rs2_i   (id_use_rs2),
      .ex_rd_i        (ex_rd),
      .ex_mem_read_i  (ex_mem_read),
      .ex_redirect_i  (ex_redirect),
      .mem_req_i      (mem_req),
      .mem_ready_i    (mem_ready),
      .halt_req_i     (halt_req),
      .pc_we_o        (pc_we),
      .ifid_we_o      (ifid_we),
      .ifid_flush_o   (ifid_flush),
      .idex_we_o      (idex_we),
      .idex_flush_o   (idex_flush),
      .exmem_we_o     (exmem_we),
      .exmem_flush_o  (exmem_flush),
      .memwb_we_o     (memwb_we),
      .memwb_flush_o  (memwb_flush),
      .halted_o       (halted),
      .mem_timeout_o  (mem_timeout),
      .stall_cycles_o (stall_cycles),
      .flush_events_o (flush_events)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state.
   int m_mode = ModeRun;
   int m_wait = 0;
   int m_left = 0;
   int m_stall = 0;
   int m_flush = 0;
   bit m_to = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // {pc, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush, memwb_we,
   //  memwb_flush, halted}
   function automatic logic [9:0] ctrl_vec();
      return {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush,
              memwb_we, memwb_flush, halted};
   endfunction

   function automatic bit mem_stall_now();
      return mem_req && !mem_ready;
   endfunction

   function automatic bit load_use_now();
      if (!ex_mem_read || ex_rd == 5'd0) return 1'b0;
      return (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
   endfunction

   function automatic logic [9:0] model_ctrl();
      if (!rst_n) return 10'b00_0000_0000;
      if (m_mode == ModeHalted || m_mode == ModeFault) return 10'b00_0000_0001;
      if (mem_stall_now()) return 10'b00_0000_0110;
      if (ex_redirect) return 10'b11_1111_0100;
      if (load_use_now()) return 10'b00_0111_0100;
      if (m_mode == ModeDrain) return 10'b01_1101_0100;
      return 10'b11_0101_0100;
   endfunction

   function automatic int sat_inc(input int v);
      return (v < CntMax) ? v + 1 : v;
   endfunction

   task automatic model_reset();
      m_mode = ModeRun;
      m_wait = 0;
      m_left = 0;
      m_stall = 0;
      m_flush = 0;
      m_to = 1'b0;
   endtask

   // Applies the rules for one negedge with the inputs currently driven.
   task automatic model_commit();
      bit ms, lu, faulted;
      ms = mem_stall_now();
      lu = load_use_now();
      faulted = 1'b0;
      if (m_mode == ModeRun || m_mode == ModeDrain) begin
         if (ms) begin
            m_wait++;
            m_stall = sat_inc(m_stall);
            if (m_wait >= Timeout) begin
               m_mode = ModeFault;
               m_to = 1'b1;
               faulted = 1'b1;
            end
         end else begin
            m_wait = 0;
            if (ex_redirect) m_flush = sat_inc(m_flush);
            else if (lu) m_stall = sat_inc(m_stall);
         end
         if (!faulted) begin
            if (m_mode == ModeRun) begin
               if (halt_req && !ms) begin
                  m_mode = ModeDrain;
                  m_left = Drain;
               end
            end else if (!halt_req) begin
               m_mode = ModeRun;
            end else if (!ms) begin
               if (ex_redirect || lu) begin
                  m_left = Drain;
               end else begin
                  m_left--;
                  if (m_left == 0) m_mode = ModeHalted;
               end
            end
         end
      end else if (m_mode == ModeHalted) begin
         m_wait = 0;
         if (!halt_req) m_mode = ModeRun;
      end
   endtask

   task automatic check_all(input string tag);
      int es, ef;
`ifdef PIPE_CTRL_PERF_EN
      es = m_stall;
      ef = m_flush;
`else
      es = 0;
      ef = 0;
`endif
      check({tag, ".ctrl"}, 32'(ctrl_vec()), 32'(model_ctrl()));
      check({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(m_to));
      check({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(es));
      check({tag, ".flush_events"}, 32'(flush_events), 32'(ef));
   endtask

   // Called in the phase just after a negedge with the inputs for this cycle driven.
   task automatic tick(input string tag);
      @(posedge clk);
      #1;
      check_all(tag);
      @(negedge clk);
      if (rst_n) model_commit();
      #1;
   endtask

   // Asserts reset mid-cycle, checks the asynchronous effect, releases after a negedge.
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("reset");
      @(negedge clk);
      #1;
      check_all("reset_hold");
      rst_n = 1'b1;
   endtask

   task automatic idle_inputs();
      id_rs1 = '0;
      id_rs2 = '0;
      ex_rd = '0;
      id_use_rs1 = 1'b0;
      id_use_rs2 = 1'b0;
      ex_mem_read = 1'b0;
      ex_redirect = 1'b0;
      mem_req = 1'b0;
      mem_ready = 1'b1;
   endtask

   task automatic random_inputs();
      id_rs1 = 5'($urandom_range(0, 7));
      id_rs2 = 5'($urandom_range(0, 7));
      ex_rd = 5'($urandom_range(0, 7));
      id_use_rs1 = 1'($urandom_range(0, 1));
      id_use_rs2 = 1'($urandom_range(0, 1));
      ex_mem_read = ($urandom_range(0, 9) < 3);
      ex_redirect = ($urandom_range(0, 9) == 0);
      mem_req = ($urandom_range(0, 9) < 3);
      mem_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) halt_req = ~halt_req;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      do_reset();

      // Load-use on rs1, then the same pattern with ex_rd = x0.
      idle_inputs();
      ex_mem_read = 1'b1;
      ex_rd = 5'd5;
      id_rs1 = 5'd5;
      id_use_rs1 = 1'b1;
      tick("loaduse");
      ex_rd = 5'd0;
      id_rs1 = 5'd0;
      tick("loaduse_x0");
      ex_rd = 5'd9;
      id_rs2 = 5'd9;
      id_use_rs1 = 1'b0;
      id_use_rs2 = 1'b1;
      tick("loaduse_rs2");

      // Redirect coincident with load-use.
      ex_redirect = 1'b1;
      tick("redir_lu");
      idle_inputs();

      // Four wait cycles, then ready.
      mem_req = 1'b1;
      mem_ready = 1'b0;
      repeat (4) tick("memwait");
      mem_ready = 1'b1;
      tick("memready");

      // Timeout: fault is sticky until reset.
      mem_ready = 1'b0;
      repeat (Timeout + 2) tick("timeout");
      check("timeout_flag", 32'(mem_timeout), 32'd1);
      check("timeout_halted", 32'(halted), 32'd1);
      mem_ready = 1'b1;
      repeat (2) tick("fault_hold");
      do_reset();
      idle_inputs();

      // Clean halt: halted rises on the 4th negedge.
      halt_req = 1'b1;
      repeat (Drain) tick("drain");
      check("halt_not_yet", 32'(halted), 32'd0);
      tick("drain_last");
      check("halt_latency", 32'(halted), 32'd1);
      tick("halted");
      halt_req = 1'b0;
      tick("unhalt");
      tick("resume");

      // Redirect mid-drain restarts the window.
      halt_req = 1'b1;
      repeat (2) tick("drain2");
      ex_redirect = 1'b1;
      tick("drain_redir");
      ex_redirect = 1'b0;
      repeat (Drain - 1) tick("drain_reload");
      check("reload_not_yet", 32'(halted), 32'd0);
      tick("drain_reload_last");
      check("reload_halted", 32'(halted), 32'd1);
      halt_req = 1'b0;
      tick("unhalt2");

      // Mid-drain drop of halt_req.
      halt_req = 1'b1;
      tick("drain3");
      halt_req = 1'b0;
      tick("drop");
      tick("run_again");

      // Counter scenario: 2 load-use + 3 waits + 1 redirect.
      do_reset();
      idle_inputs();
      ex_mem_read = 1'b1;
      ex_rd = 5'd3;
      id_rs1 = 5'd3;
      id_use_rs1 = 1'b1;
      repeat (2) tick("perf_lu");
      idle_inputs();
      mem_req = 1'b1;
      mem_ready = 1'b0;
      repeat (3) tick("perf_wait");
      idle_inputs();
      ex_redirect = 1'b1;
      tick("perf_redir");
      ex_redirect = 1'b0;
      tick("perf_idle");
`ifdef PIPE_CTRL_PERF_EN
      check("perf_stall", 32'(stall_cycles), 32'd5);
      check("perf_flush", 32'(flush_events), 32'd1);
`else
      check("perf_stall_off", 32'(stall_cycles), 32'd0);
      check("perf_flush_off", 32'(flush_events), 32'd0);
`endif

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         if (i % 1500 == 1499 || (m_mode == ModeFault && $urandom_range(0, 7) == 0)) begin
            do_reset();
         end
         random_inputs();
         tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
